// File: rtl/sched_pkg.sv
// Shared types and defaults for the vertical-blanking update scheduler.
package sched_pkg;

  localparam int unsigned TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StSnap,
    StScan,
    StGrant,
    StWaitLow
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pend at or after (last+1) mod N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         pend,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     valid
);

  localparam int unsigned IW = $clog2(N_REQ);

  logic [IW-1:0] w_j;

  always_comb begin
    idx   = last;
    valid = 1'b0;
    w_j   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      w_j = IW'((32'(last) + i) % N_REQ);
      if (!valid && pend[w_j]) begin
        idx   = w_j;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vblank_update_sched.sv
// Grants the shared game-state update path to one requester at a time during vertical blanking,
// round-robin over the requests snapshotted at blanking entry, with a per-grant timeout.
module vblank_update_sched
  import sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vblnk,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         gnt,
  output logic                     frame_start,
  output logic                     busy,
  output logic                     timeout,
  output logic [$clog2(N_REQ)-1:0] timeout_id,
  output logic                     overrun,
  output logic [15:0]              frame_cnt
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT);

  state_t           r_state;
  logic             r_vblnk_d;
  logic             r_seen_low;
  logic [N_REQ-1:0] r_pend;
  logic [IW-1:0]    r_last;
  logic [TW-1:0]    r_timer;
  logic [N_REQ-1:0] r_gnt;
  logic             r_frame_start;
  logic             r_busy;
  logic             r_timeout;
  logic [IW-1:0]    r_timeout_id;
  logic             r_overrun;
  logic [15:0]      r_frame_cnt;

  logic             w_rise;
  logic [IW-1:0]    w_idx;
  logic             w_valid;
  logic             w_end;

  // A vblnk already high at reset release must be seen low before it can count as an entry.
  assign w_rise = vblnk & ~r_vblnk_d & r_seen_low;
  assign w_end  = done[r_last] || (r_timer == TW'(TIMEOUT - 1));

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .pend  (r_pend),
    .last  (r_last),
    .idx   (w_idx),
    .valid (w_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_vblnk_d     <= 1'b0;
      r_seen_low    <= 1'b0;
      r_pend        <= '0;
      r_last        <= IW'(N_REQ - 1);
      r_timer       <= '0;
      r_gnt         <= '0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout     <= 1'b0;
      r_timeout_id  <= '0;
      r_overrun     <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_vblnk_d     <= vblnk;
      r_frame_start <= 1'b0;
      r_timeout     <= 1'b0;
      r_overrun     <= 1'b0;
      if (!vblnk) r_seen_low <= 1'b1;

      unique case (r_state)
        StIdle: begin
          if (w_rise) begin
            r_state       <= StSnap;
            r_frame_start <= 1'b1;
            r_busy        <= 1'b1;
            r_frame_cnt   <= r_frame_cnt + 16'd1;
          end
        end
        StSnap: begin
          r_pend  <= req;
          r_state <= StScan;
        end
        StScan: begin
          if (!vblnk && (r_pend != '0)) begin
            r_overrun <= 1'b1;
            r_pend    <= '0;
            r_busy    <= 1'b0;
            r_state   <= StIdle;
          end else if (!w_valid) begin
            r_state <= StWaitLow;
          end else begin
            r_gnt         <= N_REQ'(1) << w_idx;
            r_last        <= w_idx;
            r_pend[w_idx] <= 1'b0;
            r_timer       <= '0;
            r_state       <= StGrant;
          end
        end
        StGrant: begin
          r_timer <= r_timer + 1'b1;
          if (w_end) begin
            r_gnt <= '0;
            if (!done[r_last]) begin
              r_timeout    <= 1'b1;
              r_timeout_id <= r_last;
            end
            // Blanking ended during this grant: leftover work is dropped, not carried over.
            if (!vblnk) begin
              r_overrun <= |r_pend;
              r_pend    <= '0;
              r_busy    <= 1'b0;
              r_state   <= StIdle;
            end else begin
              r_state <= StScan;
            end
          end
        end
        StWaitLow: begin
          if (!vblnk) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;
  assign timeout     = r_timeout;
  assign timeout_id  = r_timeout_id;
  assign overrun     = r_overrun;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vblank_update_sched.sv
// Scoreboard bench for vblank_update_sched: stimulus queues expected events, a monitor checks them.
module tb_vblank_update_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vblnk;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [3:0]  gnt;
  logic        frame_start;
  logic        busy;
  logic        timeout;
  logic [1:0]  timeout_id;
  logic        overrun;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_err    = 0;

  int q_fs[$];
  int q_gnt[$];
  int q_w[$];
  int q_to[$];
  int q_ovr[$];

  int resp_d[4];

  vblank_update_sched #(
    .N_REQ   (4),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vblnk       (vblnk),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .frame_start (frame_start),
    .busy        (busy),
    .timeout     (timeout),
    .timeout_id  (timeout_id),
    .overrun     (overrun),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
  endtask

  function automatic int enc(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Requester model: pulses done in the resp_d-th cycle of its grant (0 = never answers).
  initial begin
    int cnt = 0;
    done = '0;
    forever begin
      @(negedge clk);
      done = '0;
      if (!rst_n || gnt == '0) begin
        cnt = 0;
      end else begin
        cnt++;
        for (int i = 0; i < 4; i++)
          if (gnt[i] && resp_d[i] != 0 && cnt == resp_d[i]) done[i] = 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    logic [3:0] prev_gnt = '0;
    int cyc = 0, fs_cyc = 0, hi_cnt = 0, lo_cnt = 0;
    bit first_pending = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_gnt = '0;
        first_pending = 0;
        hi_cnt = 0;
        lo_cnt = 0;
        continue;
      end
      chk("gnt_onehot", int'($onehot0(gnt)), 1);
      if (frame_start) begin
        if (q_fs.size() == 0) unexpected("frame_start");
        else chk("frame_cnt", frame_cnt, q_fs.pop_front());
        chk("busy_at_frame_start", busy, 1);
        first_pending = 1;
        fs_cyc = cyc;
      end
      if (prev_gnt == '0 && gnt != '0) begin
        if (q_gnt.size() == 0) unexpected("gnt_start");
        else chk("gnt_idx", enc(gnt), q_gnt.pop_front());
        if (first_pending) chk("first_gnt_latency", cyc - fs_cyc, 2);
        else chk("gnt_gap", lo_cnt, 1);
        first_pending = 0;
        hi_cnt = 1;
      end else if (prev_gnt != '0 && gnt == prev_gnt) begin
        hi_cnt++;
      end else if (prev_gnt != '0 && gnt == '0) begin
        if (q_w.size() == 0) unexpected("gnt_end");
        else chk("gnt_width", hi_cnt, q_w.pop_front());
        lo_cnt = 1;
      end else if (gnt == '0) begin
        lo_cnt++;
      end
      if (timeout) begin
        if (q_to.size() == 0) unexpected("timeout");
        else chk("timeout_id", timeout_id, q_to.pop_front());
        chk("gnt_low_at_timeout", gnt, 0);
      end
      if (overrun) begin
        if (q_ovr.size() == 0) unexpected("overrun");
        else void'(q_ovr.pop_front());
        chk("busy_low_at_overrun", busy, 0);
        chk("gnt_low_at_overrun", gnt, 0);
      end
      prev_gnt = gnt;
    end
  end

  task automatic run_frame(input logic [3:0] r, input int hi, input int lo);
    @(negedge clk);
    req   = r;
    vblnk = 1'b1;
    repeat (hi) @(negedge clk);
    chk("busy_before_vblnk_low", busy, 1);
    vblnk = 1'b0;
    repeat (lo) @(negedge clk);
    chk("busy_idle_after_frame", busy, 0);
  endtask

  task automatic set_resp(input int d0, input int d1, input int d2, input int d3);
    resp_d[0] = d0;
    resp_d[1] = d1;
    resp_d[2] = d2;
    resp_d[3] = d3;
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    vblnk = 1'b1;
    req   = '0;
    set_resp(3, 3, 3, 3);
    #23;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_timeout_id", timeout_id, 0);
    chk("rst_pulses", {frame_start, timeout, overrun}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // vblnk high across reset release must not start a frame
    repeat (6) @(negedge clk);
    chk("no_frame_from_held_vblnk", frame_cnt, 0);
    vblnk = 1'b0;
    repeat (4) @(negedge clk);

    for (int f = 1; f <= 3; f++) begin
      q_fs.push_back(f);
      run_frame(4'b0000, 10, 10);
    end

    q_fs.push_back(4);
    q_gnt = {q_gnt, 0, 1, 3};
    q_w   = {q_w, 3, 3, 3};
    run_frame(4'b1011, 40, 10);

    q_fs.push_back(5);
    q_gnt = {q_gnt, 0, 1, 3};
    q_w   = {q_w, 3, 3, 3};
    run_frame(4'b1011, 40, 10);

    q_fs.push_back(6);
    q_gnt = {q_gnt, 1, 2};
    q_w   = {q_w, 3, 3};
    run_frame(4'b0110, 40, 10);

    q_fs.push_back(7);
    q_gnt.push_back(0);
    q_w.push_back(3);
    run_frame(4'b0001, 40, 10);

    set_resp(3, 3, 0, 3);
    q_fs.push_back(8);
    q_gnt = {q_gnt, 2, 3};
    q_w   = {q_w, 16, 3};
    q_to.push_back(2);
    run_frame(4'b1100, 40, 10);
    chk("timeout_id_held", timeout_id, 2);

    set_resp(3, 10, 3, 3);
    q_fs.push_back(9);
    q_gnt.push_back(1);
    q_w.push_back(10);
    q_ovr.push_back(1);
    run_frame(4'b1010, 5, 20);

    set_resp(3, 3, 3, 3);
    q_fs.push_back(10);
    q_gnt = {q_gnt, 3, 1};
    q_w   = {q_w, 3, 3};
    run_frame(4'b1010, 40, 10);

    set_resp(10, 10, 10, 10);
    q_fs.push_back(11);
    q_gnt.push_back(2);
    @(negedge clk);
    req   = 4'b1111;
    vblnk = 1'b1;
    waited = 0;
    while (gnt == '0 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    chk("gnt_seen_before_reset", int'(gnt != '0), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_frame_cnt", frame_cnt, 0);
    chk("async_rst_timeout_id", timeout_id, 0);
    vblnk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    set_resp(3, 3, 3, 3);
    q_fs.push_back(1);
    q_gnt = {q_gnt, 0, 1, 2, 3};
    q_w   = {q_w, 3, 3, 3, 3};
    run_frame(4'b1111, 40, 10);

    repeat (5) @(negedge clk);
    chk("leftover_frame_start", q_fs.size(), 0);
    chk("leftover_gnt", q_gnt.size(), 0);
    chk("leftover_width", q_w.size(), 0);
    chk("leftover_timeout", q_to.size(), 0);
    chk("leftover_overrun", q_ovr.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
